// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial add/subtract controller.
// Imported by the controller and its adder cell.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell.
// This is the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full adder cell, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  sa_state_t state, state_d;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cmsb_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic             accept;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B on load, seed carry with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_sh    <= a_in;
      b_sh    <= b_in ^ {WIDTH{sub}};
      carry_q <= sub;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
      carry_q <= fa_co;
      cnt     <= cnt + CW'(1);
      // Carry out of slice WIDTH-2 is the carry into the MSB.
      if (cnt == CW'(WIDTH - 2)) cmsb_q <= fa_co;
      if (last) begin
        sum_q  <= {fa_s, sum_sh[WIDTH-1:1]};
        cout_q <= fa_co;
        ovf_q  <= cmsb_q ^ fa_co;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign sum_out   = sum_q;
  assign cout_out  = cout_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl (WIDTH=8)
// against an arithmetic reference model.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum_out;
  logic       cout_out;
  logic       ovf_out;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .ovf_out   (ovf_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum} from plain signed/unsigned arithmetic
  function automatic logic [9:0] ref_op(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic s);
    int ua, ub, sa, sb, r, t;
    logic [7:0] sm;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      t  = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end else begin
      t  = ua + ub;
      co = (t > 255);
      r  = sa + sb;
    end
    sm = t[7:0];
    ov = (r > 127) || (r < -128);
    return {ov, co, sm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input int stall, input bit noise);
    logic [9:0] e;
    int lat;
    e = ref_op(a, b, s);
    chk("in_ready_idle", int'(in_ready), 1);
    a_in = a;
    b_in = b;
    sub = s;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    if (noise) begin
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      sub = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("busy_run", int'(busy), 1);
      chk("in_ready_run", int'(in_ready), 0);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, 8);
    chk("sum", int'(sum_out), int'(e[7:0]));
    chk("cout", int'(cout_out), int'(e[8]));
    chk("ovf", int'(ovf_out), int'(e[9]));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      tick();
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_ready", int'(in_ready), 0);
      chk("hold_sum", int'(sum_out), int'(e[7:0]));
      chk("hold_flags", int'({ovf_out, cout_out}), int'(e[9:8]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_valid", int'(out_valid), 0);
    chk("post_ready", int'(in_ready), 1);
    chk("post_sum", int'(sum_out), int'(e[7:0]));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    sub = 1'b0;
    #12;
    chk("rst_sum", int'(sum_out), 0);
    chk("rst_flags", int'({ovf_out, cout_out}), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
    run_op(8'h10, 8'h20, 1'b1, 0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 5, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b1);
    run_op(8'h00, 8'h80, 1'b1, 1, 1'b0);

    // abort at cnt=3
    a_in = 8'h12;
    b_in = 8'h34;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_sum", int'(sum_out), 0);
    chk("abort_flags", int'({ovf_out, cout_out}), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(in_ready), 1);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_valid", int'(out_valid | busy), 0);
    end
    run_op(8'h01, 8'h02, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
